rmssd_window_sched: RTL

RMSSD_WINDOW_SCHED -- requirements
Module: rmssd_window_sched

---
 rtl/rmssd_window_sched.sv | 94 +++++++++
 1 files changed

// File: rtl/rmssd_window_sched.sv
// rmssd_window_sched: buffers RR samples and streams 8-sample windows to an RMSSD engine; RMSSD_OVERLAP_EN selects a 4-sample pop (sliding window) instead of 8
module rmssd_window_sched #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rr_in,
    input  logic       rr_valid,
    output logic       rr_ready,
    output logic       eng_rst_n,
    output logic       eng_valid,
    output logic [7:0] eng_rr,
    input  logic       eng_done,
    input  logic [7:0] eng_rmssd,
    output logic [7:0] rmssd_out,
    output logic       rmssd_valid,
    output logic       busy,
    output logic       overrun,
    output logic       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT_CYC > 8) ? $clog2(TIMEOUT_CYC) : 3;
`ifdef RMSSD_OVERLAP_EN
    localparam int POP = 4;
`else
    localparam int POP = 8;
`endif

    typedef enum logic [2:0] {S_FILL, S_KICK, S_STREAM, S_WAIT, S_CAPTURE, S_CLEAR} state_t;

    state_t          state, nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   cnt;
    logic            full, push, pop, tmo;

    assign full      = count == (AW+1)'(DEPTH);
    assign rr_ready  = !full;
    assign push      = rr_valid && !full;
    assign tmo       = state == S_WAIT && !eng_done && cnt == CW'(TIMEOUT_CYC - 1);
    assign pop       = state == S_CAPTURE || tmo;
    assign busy      = state != S_FILL;
    assign eng_valid = state == S_KICK || state == S_STREAM;
    assign eng_rr    = state == S_STREAM ? mem[rd_ptr + AW'(cnt[2:0])] : 8'd0;

    // next-state: fixed-length KICK/STREAM, WAIT ends on done or timeout
    always_comb begin
        nxt = state;
        case (state)
            S_FILL:    nxt = count >= (AW+1)'(8) ? S_KICK : S_FILL;
            S_KICK:    nxt = S_STREAM;
            S_STREAM:  nxt = cnt[2:0] == 3'd7 ? S_WAIT : S_STREAM;
            S_WAIT:    nxt = eng_done ? S_CAPTURE : (tmo ? S_CLEAR : S_WAIT);
            S_CAPTURE: nxt = S_CLEAR;
            S_CLEAR:   nxt = S_FILL;
            default:   nxt = S_FILL;
        endcase
    end

    // state register and per-state cycle counter (restarts on every transition)
    always_ff @(posedge clk) begin
        state <= rst ? S_FILL : nxt;
        cnt   <= (rst || state != nxt) ? '0 : cnt + 1'b1;
    end

    // sample storage; stale entries are harmless since pointers define contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rr_in;
    end

    // FIFO pointers and exact occupancy; the window is popped only once it is done
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(POP) : rd_ptr;
            count  <= count + (AW+1)'(push) - (pop ? (AW+1)'(POP) : '0);
        end
    end

    // result capture, engine reset strobe and sticky error flags
    always_ff @(posedge clk) begin
        eng_rst_n   <= !rst && nxt != S_CLEAR;
        rmssd_valid <= !rst && state == S_CAPTURE;
        rmssd_out   <= rst ? 8'd0 : (state == S_CAPTURE ? eng_rmssd : rmssd_out);
        overrun     <= !rst && (overrun || (rr_valid && full));
        timeout     <= !rst && (timeout || tmo);
    end
endmodule
